// File: rtl/ysyx_22041207_mem_rd_arbiter.sv
// Read arbiter that shares one memory read channel between IF and LS, with one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration; otherwise LS always wins over IF.
module ysyx_22041207_mem_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_r_valid_i,
  output logic              if_r_ready_o,
  input  logic [ADDR_W-1:0] if_r_addr_i,
  input  logic [SIZE_W-1:0] if_r_size_i,
  output logic              if_data_valid_o,
  input  logic              if_data_ready_i,
  output logic [DATA_W-1:0] if_data_o,
  input  logic              ls_r_valid_i,
  output logic              ls_r_ready_o,
  input  logic [ADDR_W-1:0] ls_r_addr_i,
  input  logic [SIZE_W-1:0] ls_r_size_i,
  output logic              ls_data_valid_o,
  input  logic              ls_data_ready_i,
  output logic [DATA_W-1:0] ls_data_o,
  output logic              mem_r_valid_o,
  input  logic              mem_r_ready_i,
  output logic [ADDR_W-1:0] mem_r_addr_o,
  output logic [SIZE_W-1:0] mem_r_size_o,
  input  logic              mem_data_valid_i,
  output logic              mem_data_ready_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        owner_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_LS   = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              prefer_ls;
  logic              grant_ls;
  logic              grant_if;
  logic              data_rdy;

`ifdef ARB_RR_EN
  // Set when IF owned the last completed transaction, so LS is favoured next.
  logic              last_if_q, last_if_d;
  assign prefer_ls = last_if_q;
`else
  assign prefer_ls = 1'b1;
`endif

  assign grant_ls = ls_r_valid_i && (prefer_ls || !if_r_valid_i);
  assign grant_if = if_r_valid_i && !grant_ls;

  assign mem_r_valid_o = (state_q == ADDR);
  assign mem_r_addr_o  = addr_q;
  assign mem_r_size_o  = size_q;
  assign owner_o       = owner_q;

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    addr_d           = addr_q;
    size_d           = size_q;
`ifdef ARB_RR_EN
    last_if_d        = last_if_q;
`endif
    if_r_ready_o     = 1'b0;
    ls_r_ready_o     = 1'b0;
    if_data_valid_o  = 1'b0;
    ls_data_valid_o  = 1'b0;
    if_data_o        = '0;
    ls_data_o        = '0;
    data_rdy         = 1'b0;
    mem_data_ready_o = 1'b0;

    case (state_q)
      IDLE: begin
        if_r_ready_o = grant_if;
        ls_r_ready_o = grant_ls;
        if (grant_ls || grant_if) begin
          addr_d  = grant_ls ? ls_r_addr_i : if_r_addr_i;
          size_d  = grant_ls ? ls_r_size_i : if_r_size_i;
          owner_d = grant_ls ? OWN_LS : OWN_IF;
          state_d = ADDR;
        end
      end
      // Read data arriving before the address is accepted is not ours to forward.
      ADDR: begin
        if (mem_r_ready_i) state_d = DATA;
      end
      DATA: begin
        if (owner_q == OWN_LS) begin
          ls_data_valid_o = mem_data_valid_i;
          ls_data_o       = mem_data_i;
          data_rdy        = ls_data_ready_i;
        end else begin
          if_data_valid_o = mem_data_valid_i;
          if_data_o       = mem_data_i;
          data_rdy        = if_data_ready_i;
        end
        mem_data_ready_o = data_rdy;
        if (mem_data_valid_i && data_rdy) begin
          state_d   = IDLE;
          owner_d   = OWN_NONE;
`ifdef ARB_RR_EN
          last_if_d = (owner_q == OWN_IF);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      addr_q    <= '0;
      size_q    <= '0;
`ifdef ARB_RR_EN
      last_if_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
`ifdef ARB_RR_EN
      last_if_q <= last_if_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mem_rd_arbiter.sv
// Scoreboard bench for ysyx_22041207_mem_rd_arbiter: stimulus queues expected requests/responses, a monitor checks them.
module tb_ysyx_22041207_mem_rd_arbiter;

  typedef struct packed {logic [1:0] own; logic [63:0] addr; logic [7:0] size;} req_t;
  typedef struct packed {logic [1:0] dest; logic [63:0] data;} rsp_t;

  localparam logic [1:0] IFD = 2'b01;
  localparam logic [1:0] LSD = 2'b10;

  logic        clk, rst;
  logic        if_r_valid_i, if_r_ready_o, if_data_valid_o, if_data_ready_i;
  logic [63:0] if_r_addr_i, if_data_o;
  logic [7:0]  if_r_size_i;
  logic        ls_r_valid_i, ls_r_ready_o, ls_data_valid_o, ls_data_ready_i;
  logic [63:0] ls_r_addr_i, ls_data_o;
  logic [7:0]  ls_r_size_i;
  logic        mem_r_valid_o, mem_r_ready_i, mem_data_valid_i, mem_data_ready_o;
  logic [63:0] mem_r_addr_o, mem_data_i;
  logic [7:0]  mem_r_size_o;
  logic [1:0]  owner_o;

  int checks = 0;
  int errors = 0;
  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  req_t mon_req;
  rsp_t mon_rsp;
  logic [1:0] mon_got;

  ysyx_22041207_mem_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .if_r_valid_i(if_r_valid_i), .if_r_ready_o(if_r_ready_o),
    .if_r_addr_i(if_r_addr_i), .if_r_size_i(if_r_size_i),
    .if_data_valid_o(if_data_valid_o), .if_data_ready_i(if_data_ready_i), .if_data_o(if_data_o),
    .ls_r_valid_i(ls_r_valid_i), .ls_r_ready_o(ls_r_ready_o),
    .ls_r_addr_i(ls_r_addr_i), .ls_r_size_i(ls_r_size_i),
    .ls_data_valid_o(ls_data_valid_o), .ls_data_ready_i(ls_data_ready_i), .ls_data_o(ls_data_o),
    .mem_r_valid_o(mem_r_valid_o), .mem_r_ready_i(mem_r_ready_i),
    .mem_r_addr_o(mem_r_addr_o), .mem_r_size_o(mem_r_size_o),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_ready_o(mem_data_ready_o), .mem_data_i(mem_data_i),
    .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted memory request and every delivered response is popped and compared.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_r_valid_o === 1'b1 && mem_r_ready_i === 1'b1) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: actual addr 0x%0h required no request", mem_r_addr_o);
        end else begin
          mon_req = exp_req_q.pop_front();
          chk("req", {owner_o, mem_r_addr_o, mem_r_size_o}, mon_req);
        end
      end
      mon_got = {ls_data_valid_o & ls_data_ready_i, if_data_valid_o & if_data_ready_i};
      if (mon_got != 2'b00) begin
        if (exp_rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: actual dest %b required no response", mon_got);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          chk("rsp", {mem_data_ready_o, mon_got, mon_got[1] ? ls_data_o : if_data_o},
              {1'b1, mon_rsp.dest, mon_rsp.data});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Raise one requester in IDLE, expect its same-cycle ready, then the latched request next cycle.
  task automatic issue(input bit ls, input logic [63:0] a, input logic [7:0] s);
    if (ls) begin
      ls_r_valid_i = 1'b1; ls_r_addr_i = a; ls_r_size_i = s;
    end else begin
      if_r_valid_i = 1'b1; if_r_addr_i = a; if_r_size_i = s;
    end
    exp_req_q.push_back(req_t'({ls ? LSD : IFD, a, s}));
    #1;
    chk("grant_ready", {ls_r_ready_o, if_r_ready_o}, ls ? LSD : IFD);
    tick;
    if_r_valid_i = 1'b0;
    ls_r_valid_i = 1'b0;
    chk("addr_valid", {mem_r_valid_o, mem_r_addr_o, mem_r_size_o}, {1'b1, a, s});
  endtask

  // Entered in ADDR: stall address aw cycles, then stall data dw cycles, then deliver d.
  task automatic serve(input int aw, input int dw, input logic [1:0] dest,
                       input logic [63:0] a, input logic [63:0] d);
    mem_r_ready_i = 1'b0;
    repeat (aw) begin
      tick;
      chk("addr_hold", {mem_r_valid_o, mem_r_addr_o}, {1'b1, a});
    end
    mem_r_ready_i = 1'b1;
    tick;
    mem_r_ready_i    = 1'b0;
    mem_data_valid_i = 1'b1;
    mem_data_i       = d;
    if_data_ready_i  = 1'b0;
    ls_data_ready_i  = 1'b0;
    repeat (dw) begin
      #1;
      chk("data_stall", {mem_data_ready_o, owner_o, ls_data_valid_o, if_data_valid_o}, {1'b0, dest, dest});
      tick;
    end
    if_data_ready_i = 1'b1;
    ls_data_ready_i = 1'b1;
    exp_rsp_q.push_back(rsp_t'({dest, d}));
    tick;
    mem_data_valid_i = 1'b0;
    if_data_ready_i  = 1'b0;
    ls_data_ready_i  = 1'b0;
    chk("owner_clear", owner_o, 2'b00);
  endtask

  logic [1:0] seq [4];
  int nseq;
  bit more_ls, more_if;

  initial begin
    rst = 1'b1;
    if_r_valid_i = 0; if_r_addr_i = '0; if_r_size_i = '0; if_data_ready_i = 0;
    ls_r_valid_i = 0; ls_r_addr_i = '0; ls_r_size_i = '0; ls_data_ready_i = 0;
    mem_r_ready_i = 0; mem_data_valid_i = 0; mem_data_i = '0;
    do_reset;

    // Reset state
    chk("rst_ctrl", {mem_r_valid_o, mem_r_addr_o, mem_r_size_o, owner_o}, '0);
    chk("rst_outs", {if_r_ready_o, ls_r_ready_o, if_data_valid_o, ls_data_valid_o,
                     mem_data_ready_o, if_data_o, ls_data_o}, '0);

    // IF only
    issue(1'b0, 64'h8000_0000, 8'h0F);
    chk("owner_if", owner_o, IFD);
    serve(0, 0, IFD, 64'h8000_0000, 64'h0000_0000_0000_0013);

    // Both requesters held valid
    do_reset;
`ifdef ARB_RR_EN
    seq[0] = LSD; seq[1] = IFD; seq[2] = LSD; seq[3] = IFD; nseq = 4;
`else
    seq[0] = LSD; seq[1] = LSD; seq[2] = IFD; seq[3] = IFD; nseq = 3;
`endif
    for (int k = 0; k < nseq; k++)
      exp_req_q.push_back(req_t'({seq[k], seq[k] == LSD ? 64'h8000_1000 : 64'h8000_0004,
                                  seq[k] == LSD ? 8'h03 : 8'h0F}));
    if_r_valid_i = 1'b1; if_r_addr_i = 64'h8000_0004; if_r_size_i = 8'h0F;
    ls_r_valid_i = 1'b1; ls_r_addr_i = 64'h8000_1000; ls_r_size_i = 8'h03;
    for (int k = 0; k < nseq; k++) begin
      for (int i = 0; i < 10 && mem_r_valid_o !== 1'b1; i++) tick;
      if (mem_r_valid_o !== 1'b1) begin
        checks++; errors++;
        $display("FAIL arb_timeout: actual no grant for step %0d required grant", k);
      end
      more_ls = 0; more_if = 0;
      for (int j = k + 1; j < nseq; j++) begin
        if (seq[j] == LSD) more_ls = 1;
        if (seq[j] == IFD) more_if = 1;
      end
      if (!more_ls) ls_r_valid_i = 1'b0;
      if (!more_if) if_r_valid_i = 1'b0;
      serve(0, 0, seq[k], 64'h0, 64'h0000_0000_0000_1000 + 64'(k));
    end

    // Backpressure on both address and data phases
    issue(1'b1, 64'h8000_2008, 8'h03);
    serve(5, 4, LSD, 64'h8000_2008, 64'hDEAD_BEEF_0000_0001);

    // Stray data during ADDR
    issue(1'b0, 64'h8000_0010, 8'h0F);
    mem_data_valid_i = 1'b1;
    mem_data_i       = 64'h0000_0000_0000_0BAD;
    if_data_ready_i  = 1'b1;
    repeat (2) begin
      #1;
      chk("stray", {if_data_valid_o, ls_data_valid_o, mem_data_ready_o, mem_r_valid_o, owner_o},
          {3'b000, 1'b1, IFD});
      tick;
    end
    mem_data_valid_i = 1'b0;
    if_data_ready_i  = 1'b0;
    serve(0, 0, IFD, 64'h8000_0010, 64'h0000_0000_0000_0055);

    // Reset while in DATA
    issue(1'b0, 64'h8000_0020, 8'h0F);
    mem_r_ready_i = 1'b1;
    tick;
    mem_r_ready_i    = 1'b0;
    mem_data_valid_i = 1'b1;
    mem_data_i       = 64'h0000_0000_0000_0077;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_data", {mem_r_valid_o, owner_o, if_data_valid_o, ls_data_valid_o, mem_data_ready_o}, '0);
    if_data_ready_i = 1'b1;
    #1;
    chk("rst_noready", {mem_data_ready_o, if_data_valid_o}, 2'b00);
    mem_data_valid_i = 1'b0;
    if_data_ready_i  = 1'b0;
    tick;
    issue(1'b0, 64'h8000_0030, 8'h0F);
    serve(1, 1, IFD, 64'h8000_0030, 64'h0000_0000_0000_0099);

    tick;
    chk("queues_empty", {32'(exp_req_q.size()), 32'(exp_rsp_q.size())}, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
